// File: rtl/rx_nibble_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_nibble_packer_pkg
// Description : Shared widths and FSM state encoding for the nibble packer.
// Revision    : 1.0  initial release
// ============================================================================
package rx_nibble_packer_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int WORD_CNT_W = 8;

    // IDLE: no nibbles held. COLLECT: 1..NIB_PER_WORD-1 nibbles held.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

endpackage : rx_nibble_packer_pkg
`default_nettype wire

// File: rtl/rx_nibble_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_nibble_packer_if
// Description : Nibble input, word output and status signals of the packer.
//               slave  - packer side (consumes nibbles, produces words)
//               master - environment side (produces nibbles, consumes words)
// Ports       : i_nib_vld, i_nib, i_flush, i_clr_ovf, i_word_rdy (to packer)
//               o_word, o_word_vld, o_overflow, o_word_cnt (from packer)
// Revision    : 1.0  initial release
// ============================================================================
interface rx_nibble_packer_if #(
    parameter int NIB_PER_WORD = 4
) ();
    import rx_nibble_packer_pkg::*;

    logic                             i_nib_vld;
    logic [NIBBLE_W-1:0]              i_nib;
    logic                             i_flush;
    logic                             i_clr_ovf;
    logic                             i_word_rdy;
    logic [NIBBLE_W*NIB_PER_WORD-1:0] o_word;
    logic                             o_word_vld;
    logic                             o_overflow;
    logic [WORD_CNT_W-1:0]            o_word_cnt;

    modport slave (
        input  i_nib_vld, i_nib, i_flush, i_clr_ovf, i_word_rdy,
        output o_word, o_word_vld, o_overflow, o_word_cnt
    );

    modport master (
        output i_nib_vld, i_nib, i_flush, i_clr_ovf, i_word_rdy,
        input  o_word, o_word_vld, o_overflow, o_word_cnt
    );

endinterface : rx_nibble_packer_if
`default_nettype wire

// File: rtl/sync_fifo_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ff
// Description : Single-clock flop-based FIFO with first-word-fall-through.
//               A push is accepted when not full, or when full and a pop
//               happens in the same cycle. o_data reads 0 while empty.
// Ports       : clk, rst_n (async active-low), i_push/i_data,
//               i_pop, o_data (head entry), o_full, o_empty
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_ff #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        o_full  = (count_q == CW'(DEPTH));
        o_empty = (count_q == '0);
        o_data  = o_empty ? '0 : mem_q[rd_ptr_q];
        rd_en   = i_pop && !o_empty;
        // Full-with-pop frees the head slot in the same edge.
        wr_en   = i_push && (!o_full || rd_en);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : sync_fifo_ff
`default_nettype wire

// File: rtl/rx_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module      : rx_nibble_packer
// Description : Packs NIB_PER_WORD 4-bit nibbles LSB-first into a word and
//               queues completed words in a small FWFT buffer. Words that
//               complete while the buffer is full (and not draining) are
//               dropped and flagged with a sticky overflow.
// Ports       : i_clk_b   - clock, rising edge
//               i_rst_n   - asynchronous active-low reset
//               bus       - nibble in / word out / status (slave modport)
// Revision    : 1.0  initial release
// ============================================================================
module rx_nibble_packer #(
    parameter int NIB_PER_WORD = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  wire logic       i_clk_b,
    input  wire logic       i_rst_n,
    rx_nibble_packer_if.slave bus
);
    import rx_nibble_packer_pkg::*;

    localparam int                WORD_W   = NIBBLE_W * NIB_PER_WORD;
    localparam int                IDX_W    = $clog2(NIB_PER_WORD);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIB_PER_WORD - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [WORD_W-1:0]     asm_q,   asm_d;
    logic                  ovf_q,   ovf_d;
    logic [WORD_CNT_W-1:0] cnt_q,   cnt_d;

    logic [IDX_W-1:0]      nib_pos;
    logic [WORD_W-1:0]     word_next;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_W-1:0]     fifo_data;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        push    = 1'b0;

        pop     = !fifo_empty && bus.i_word_rdy;

        // In IDLE the incoming nibble is always nibble 0 of a new word.
        nib_pos = (state_q == ST_IDLE) ? '0 : idx_q;
        word_next = asm_q;
        word_next[nib_pos*NIBBLE_W +: NIBBLE_W] = bus.i_nib;

        // Clear is applied first so a same-cycle drop overrides it.
        if (bus.i_clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (bus.i_flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            asm_d   = '0;
        end else if (bus.i_nib_vld) begin
            if (nib_pos == LAST_IDX) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                asm_d   = '0;
                if (!fifo_full || pop) begin
                    push  = 1'b1;
                    cnt_d = cnt_q + WORD_CNT_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                state_d = ST_COLLECT;
                idx_d   = nib_pos + IDX_W'(1);
                asm_d   = word_next;
            end
        end
    end

    always_ff @(posedge i_clk_b or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    sync_fifo_ff #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk_b),
        .rst_n   (i_rst_n),
        .i_push  (push),
        .i_data  (word_next),
        .i_pop   (pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign bus.o_word     = fifo_data;
    assign bus.o_word_vld = !fifo_empty;
    assign bus.o_overflow = ovf_q;
    assign bus.o_word_cnt = cnt_q;

endmodule : rx_nibble_packer
`default_nettype wire

// File: tb/tb_rx_nibble_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_nibble_packer
// Description : Self-checking bench for rx_nibble_packer. A queue-based model
//               predicts outputs every cycle; directed scenarios add literal
//               expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_nibble_packer;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rx_nibble_packer_if #(.NIB_PER_WORD(N)) bus ();

    rx_nibble_packer #(
        .NIB_PER_WORD (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk_b (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  m_nibs [$];
    logic [15:0] m_fifo [$];
    bit          m_ovf;
    int          m_cnt;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_nibs.delete();
            m_fifo.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            bit          do_pop;
            logic [15:0] w;
            chk("m_vld", 32'(bus.o_word_vld), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) chk("m_word", 32'(bus.o_word), 32'(m_fifo[0]));
            chk("m_ovf", 32'(bus.o_overflow), 32'(m_ovf));
            chk("m_cnt", 32'(bus.o_word_cnt), 32'(m_cnt));

            do_pop = (m_fifo.size() != 0) && bus.i_word_rdy;
            if (do_pop) void'(m_fifo.pop_front());
            if (bus.i_clr_ovf) m_ovf = 1'b0;
            if (bus.i_flush) begin
                m_nibs.delete();
            end else if (bus.i_nib_vld) begin
                m_nibs.push_back(bus.i_nib);
                if (m_nibs.size() == N) begin
                    w = '0;
                    for (int k = 0; k < N; k++) w = w | (16'(m_nibs[k]) << (4 * k));
                    m_nibs.delete();
                    if (m_fifo.size() < DEPTH) begin
                        m_fifo.push_back(w);
                        m_cnt = (m_cnt + 1) % 256;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic vld, input logic [3:0] nib, input logic flush,
                       input logic clr, input logic rdy);
        @(posedge clk);
        #1;
        bus.i_nib_vld  = vld;
        bus.i_nib      = nib;
        bus.i_flush    = flush;
        bus.i_clr_ovf  = clr;
        bus.i_word_rdy = rdy;
    endtask

    task automatic nib(input logic [3:0] n, input logic rdy);
        cyc(1'b1, n, 1'b0, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.i_nib_vld  = 1'b0;
        bus.i_nib      = 4'h0;
        bus.i_flush    = 1'b0;
        bus.i_clr_ovf  = 1'b0;
        bus.i_word_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus.i_nib_vld  = 1'b0;
        bus.i_nib      = 4'h0;
        bus.i_flush    = 1'b0;
        bus.i_clr_ovf  = 1'b0;
        bus.i_word_rdy = 1'b0;
        #3;
        chk("rst_vld",  32'(bus.o_word_vld), 32'd0);
        chk("rst_word", 32'(bus.o_word),     32'd0);
        chk("rst_ovf",  32'(bus.o_overflow), 32'd0);
        chk("rst_cnt",  32'(bus.o_word_cnt), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic packing, one-cycle latency, rdy=1 on empty buffer is harmless
        nib(4'h1, 1'b1); nib(4'h2, 1'b1); nib(4'h3, 1'b1); nib(4'h4, 1'b1);
        @(negedge clk);
        chk("lat_vld_low", 32'(bus.o_word_vld), 32'd0);
        idle(1'b1);
        @(negedge clk);
        chk("basic_vld",  32'(bus.o_word_vld), 32'd1);
        chk("basic_word", 32'(bus.o_word),     32'h4321);
        chk("basic_cnt",  32'(bus.o_word_cnt), 32'd1);
        idle(1'b1);
        @(negedge clk);
        chk("basic_drained", 32'(bus.o_word_vld), 32'd0);

        // Overflow with full buffer, then push-with-pop on a full buffer
        do_reset();
        for (int w = 1; w <= 3; w++)
            for (int k = 0; k < N; k++) nib(4'(w), 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("ovf_set",  32'(bus.o_overflow), 32'd1);
        chk("ovf_cnt",  32'(bus.o_word_cnt), 32'd2);
        chk("ovf_head", 32'(bus.o_word),     32'h1111);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("clr_pending", 32'(bus.o_overflow), 32'd1);
        nib(4'hF, 1'b0); nib(4'hE, 1'b0); nib(4'hE, 1'b0); nib(4'hB, 1'b1);
        @(negedge clk);
        chk("pp_head_pre", 32'(bus.o_word), 32'h1111);
        idle(1'b0);
        @(negedge clk);
        chk("pp_ovf",  32'(bus.o_overflow), 32'd0);
        chk("pp_cnt",  32'(bus.o_word_cnt), 32'd3);
        chk("pp_head", 32'(bus.o_word),     32'h2222);
        idle(1'b1);
        @(negedge clk);
        chk("pp_second", 32'(bus.o_word), 32'h2222);
        idle(1'b1);
        @(negedge clk);
        chk("pp_third", 32'(bus.o_word), 32'hBEEF);
        idle(1'b1);
        @(negedge clk);
        chk("pp_empty", 32'(bus.o_word_vld), 32'd0);

        // Flush concurrent with a nibble discards the partial word
        do_reset();
        nib(4'hA, 1'b0); nib(4'hB, 1'b0);
        cyc(1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        nib(4'h5, 1'b0); nib(4'h6, 1'b0); nib(4'h7, 1'b0); nib(4'h8, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("flush_word", 32'(bus.o_word),     32'h8765);
        chk("flush_cnt",  32'(bus.o_word_cnt), 32'd1);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("flush_keeps", 32'(bus.o_word), 32'h8765);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("flush_single", 32'(bus.o_word_vld), 32'd0);

        // Asynchronous reset mid-word with a buffered word
        do_reset();
        nib(4'h1, 1'b0); nib(4'h2, 1'b0); nib(4'h3, 1'b0); nib(4'h4, 1'b0);
        nib(4'h9, 1'b0); nib(4'h9, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("pre_rst_word", 32'(bus.o_word), 32'h4321);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld",  32'(bus.o_word_vld), 32'd0);
        chk("arst_word", 32'(bus.o_word),     32'd0);
        chk("arst_cnt",  32'(bus.o_word_cnt), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nib(4'hF, 1'b0); nib(4'hE, 1'b0); nib(4'hD, 1'b0); nib(4'hC, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("post_rst_word", 32'(bus.o_word),     32'hCDEF);
        chk("post_rst_cnt",  32'(bus.o_word_cnt), 32'd1);

        // Counter wrap after 256 pushes, then clear coincident with a drop
        do_reset();
        for (int w = 0; w < 256; w++)
            for (int k = 0; k < N; k++) nib(4'(w + k), 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("wrap_cnt", 32'(bus.o_word_cnt), 32'd0);
        chk("wrap_vld", 32'(bus.o_word_vld), 32'd1);
        // buffer holds 1 word; one more fills it, next two are dropped
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < N; k++) nib(4'h6, 1'b0);
        for (int k = 0; k < N - 1; k++) nib(4'h7, 1'b0);
        cyc(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("clr_vs_set", 32'(bus.o_overflow), 32'd1);
        chk("drop_cnt",   32'(bus.o_word_cnt), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("clr_alone", 32'(bus.o_overflow), 32'd0);

        idle(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rx_nibble_packer
`default_nettype wire
